// File: rtl/dvi_pattern_generator_pkg.sv
// Shared definitions for the DVI test-pattern generator: mode codes, colour constants, bar lookup.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package dvi_pattern_generator_pkg;

  typedef enum logic [1:0] {
    DVI_MODE_BARS  = 2'd0,
    DVI_MODE_SOLID = 2'd1,
    DVI_MODE_CHECK = 2'd2,
    DVI_MODE_RAMP  = 2'd3
  } dvi_mode_e;

  // Colours are packed {R[7:0], G[7:0], B[7:0]}
  localparam logic [23:0] DVI_WHITE   = 24'hFFFFFF;
  localparam logic [23:0] DVI_YELLOW  = 24'hFFFF00;
  localparam logic [23:0] DVI_CYAN    = 24'h00FFFF;
  localparam logic [23:0] DVI_GREEN   = 24'h00FF00;
  localparam logic [23:0] DVI_MAGENTA = 24'hFF00FF;
  localparam logic [23:0] DVI_RED     = 24'hFF0000;
  localparam logic [23:0] DVI_BLUE    = 24'h0000FF;
  localparam logic [23:0] DVI_BLACK   = 24'h000000;

  // Standard colour-bar order, left to right
  function automatic logic [23:0] bar_color(input logic [2:0] bar);
    logic [23:0] c;
    case (bar)
      3'd0:    c = DVI_WHITE;
      3'd1:    c = DVI_YELLOW;
      3'd2:    c = DVI_CYAN;
      3'd3:    c = DVI_GREEN;
      3'd4:    c = DVI_MAGENTA;
      3'd5:    c = DVI_RED;
      3'd6:    c = DVI_BLUE;
      default: c = DVI_BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dvi_pattern_generator_timing_counter.sv
// dvi_timing_counter: phase/h/v counters with sync, data-enable, x/y and frame-start decode.
// Latency: decode is combinational from the counter registers; counters advance every clock.
// Backpressure: none; en=0 holds all counters at zero so the next enabled clock is a frame start.
module dvi_timing_counter #(
  parameter int H_ACTIVE_COUNT = 24,
  parameter int H_FRONT_PORCH  = 2,
  parameter int H_SYNC         = 8,
  parameter int H_BACK_PORCH   = 4,
  parameter int V_ACTIVE_COUNT = 16,
  parameter int V_FRONT_PORCH  = 2,
  parameter int V_SYNC         = 4,
  parameter int V_BACK_PORCH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        phase,
  output logic        hs_act,
  output logic        vs_act,
  output logic        de,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        frame_start
);
  localparam int H_TOTAL = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH + H_ACTIVE_COUNT;
  localparam int V_TOTAL = V_ACTIVE_COUNT + V_FRONT_PORCH + V_SYNC + V_BACK_PORCH;
  localparam int H_BLANK = H_FRONT_PORCH + H_SYNC + H_BACK_PORCH;
  localparam int V_SYNC_START = V_ACTIVE_COUNT + V_FRONT_PORCH;
  localparam int H_W = $clog2(H_TOTAL) + 1;
  localparam int V_W = $clog2(V_TOTAL) + 1;

  logic           phase_q, phase_d;
  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           h_act, v_act;

  // Next counter state: h steps on the second half-clock, v steps on h wrap
  always_comb begin
    phase_d = phase_q;
    h_d     = h_q;
    v_d     = v_q;
    if (!en) begin
      phase_d = 1'b0;
      h_d     = '0;
      v_d     = '0;
    end else begin
      phase_d = ~phase_q;
      if (phase_q) begin
        if (h_q == H_W'(H_TOTAL - 1)) begin
          h_d = '0;
          v_d = (v_q == V_W'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
        end else begin
          h_d = h_q + 1'b1;
        end
      end
    end
  end

  // Counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= 1'b0;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      phase_q <= phase_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Region decode: line is porch/sync/porch/active, frame is active/porch/sync/porch
  always_comb begin
    h_act       = (h_q >= H_W'(H_BLANK));
    v_act       = (v_q < V_W'(V_ACTIVE_COUNT));
    hs_act      = (h_q >= H_W'(H_FRONT_PORCH)) && (h_q < H_W'(H_FRONT_PORCH + H_SYNC));
    vs_act      = (v_q >= V_W'(V_SYNC_START)) && (v_q < V_W'(V_SYNC_START + V_SYNC));
    de          = h_act && v_act;
    x           = h_act ? 16'(h_q - H_W'(H_BLANK)) : 16'd0;
    y           = 16'(v_q);
    phase       = phase_q;
    frame_start = en && !phase_q && (h_q == '0) && (v_q == '0);
  end

endmodule

// File: rtl/dvi_pattern_generator.sv
// dvi_pattern_generator: video timing plus selectable RGB test pattern, each pixel sent as two 12-bit half-words.
// Latency: every output is registered, one clock after the timing counter state it describes.
// Backpressure: none, free-running while iEnable=1; DVI_PATTERN_BORDER_EN adds a 2-pixel white border.
module dvi_pattern_generator
  import dvi_pattern_generator_pkg::*;
#(
  parameter int   H_ACTIVE_COUNT = 24,
  parameter int   H_FRONT_PORCH  = 2,
  parameter int   H_SYNC         = 8,
  parameter int   H_BACK_PORCH   = 4,
  parameter int   V_ACTIVE_COUNT = 16,
  parameter int   V_FRONT_PORCH  = 2,
  parameter int   V_SYNC         = 4,
  parameter int   V_BACK_PORCH   = 8,
  parameter logic HS_POL         = 1'b0,
  parameter logic VS_POL         = 1'b0,
  parameter int   CHECK_LOG2     = 2,
  parameter int   FRAME_CNT_W    = 8
) (
  input  logic                   iClk,
  input  logic                   iRst,
  input  logic                   iEnable,
  input  logic [1:0]             iMode,
  input  logic [23:0]            iColor,
  output logic [11:0]            oData,
  output logic                   oHsync,
  output logic                   oVsync,
  output logic                   oDe,
  output logic                   oFrameStart,
  output logic [FRAME_CNT_W-1:0] oFrameCount
);
  // Remainder pixels fall into the last (black) bar
  localparam int BAR_W = H_ACTIVE_COUNT / 8;

  logic        phase, hs_act, vs_act, de, frame_start;
  logic [15:0] x, y;

  dvi_timing_counter #(
    .H_ACTIVE_COUNT(H_ACTIVE_COUNT), .H_FRONT_PORCH(H_FRONT_PORCH),
    .H_SYNC(H_SYNC), .H_BACK_PORCH(H_BACK_PORCH),
    .V_ACTIVE_COUNT(V_ACTIVE_COUNT), .V_FRONT_PORCH(V_FRONT_PORCH),
    .V_SYNC(V_SYNC), .V_BACK_PORCH(V_BACK_PORCH)
  ) u_timing (
    .clk(iClk), .rst(iRst), .en(iEnable),
    .phase(phase), .hs_act(hs_act), .vs_act(vs_act), .de(de),
    .x(x), .y(y), .frame_start(frame_start)
  );

  dvi_mode_e              mode_q, mode_d;
  logic [23:0]            color_q, color_d;
  logic [11:0]            data_q, data_d;
  logic                   hsync_q, hsync_d, vsync_q, vsync_d;
  logic                   de_q, de_d, fs_q, fs_d;
  logic [FRAME_CNT_W-1:0] fcnt_q, fcnt_d;
  logic [15:0]            bar_full;
  logic [2:0]             bar_idx;
  logic [23:0]            rgb;

  // Colour of the current pixel under the latched mode
  always_comb begin
    bar_full = x / 16'(BAR_W);
    bar_idx  = (bar_full > 16'd7) ? 3'd7 : bar_full[2:0];
    rgb      = DVI_BLACK;
    case (mode_q)
      DVI_MODE_BARS:  rgb = bar_color(bar_idx);
      DVI_MODE_SOLID: rgb = phase ? color_q : iColor;
      DVI_MODE_CHECK: rgb = (|(((x ^ y) >> CHECK_LOG2) & 16'd1)) ? DVI_WHITE : DVI_BLACK;
      DVI_MODE_RAMP:  rgb = {x[7:0], x[7:0], x[7:0]};
    endcase
`ifdef DVI_PATTERN_BORDER_EN
    if ((x < 16'd2) || (x >= 16'(H_ACTIVE_COUNT - 2)) ||
        (y < 16'd2) || (y >= 16'(V_ACTIVE_COUNT - 2))) begin
      rgb = DVI_WHITE;
    end
`endif
  end

  // Output register next state; disabling returns everything to reset values
  always_comb begin
    mode_d  = mode_q;
    color_d = color_q;
    data_d  = 12'h000;
    hsync_d = ~HS_POL;
    vsync_d = ~VS_POL;
    de_d    = 1'b0;
    fs_d    = 1'b0;
    fcnt_d  = fcnt_q;
    if (!iEnable) begin
      mode_d  = DVI_MODE_BARS;
      color_d = '0;
      fcnt_d  = '0;
    end else begin
      if (frame_start) begin
        mode_d = dvi_mode_e'(iMode);
        fcnt_d = fcnt_q + 1'b1;
      end
      if (!phase) color_d = iColor;
      // Low half-word {G[3:0],B} first, then {R,G[7:4]}
      if (de) data_d = phase ? rgb[23:12] : rgb[11:0];
      hsync_d = hs_act ? HS_POL : ~HS_POL;
      vsync_d = vs_act ? VS_POL : ~VS_POL;
      de_d    = de;
      fs_d    = frame_start;
    end
  end

  // Output and mode/colour registers
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mode_q  <= DVI_MODE_BARS;
      color_q <= '0;
      data_q  <= 12'h000;
      hsync_q <= ~HS_POL;
      vsync_q <= ~VS_POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      mode_q  <= mode_d;
      color_q <= color_d;
      data_q  <= data_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign oData       = data_q;
  assign oHsync      = hsync_q;
  assign oVsync      = vsync_q;
  assign oDe         = de_q;
  assign oFrameStart = fs_q;
  assign oFrameCount = fcnt_q;

endmodule

// File: tb/tb_dvi_pattern_generator.sv
// Testbench for dvi_pattern_generator: reference model derives every output from clocks-since-enable.
// Latency: model expects outputs one clock after the counter state they describe.
// Backpressure: none; iEnable toggled to restart timing.
module tb_dvi_pattern_generator;
  localparam int FCW = 3;
  localparam int HT = 38;
  localparam int VT = 30;
  localparam int FRAME_CLK = 2 * HT * VT;
  localparam int H_ACT_START = 14;
  localparam logic [23:0] BAR_TAB [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                          24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  logic           iClk = 1'b0;
  logic           iRst, iEnable;
  logic [1:0]     iMode;
  logic [23:0]    iColor;
  logic [11:0]    oData;
  logic           oHsync, oVsync, oDe, oFrameStart;
  logic [FCW-1:0] oFrameCount;

  dvi_pattern_generator #(.FRAME_CNT_W(FCW)) dut (
    .iClk(iClk), .iRst(iRst), .iEnable(iEnable), .iMode(iMode), .iColor(iColor),
    .oData(oData), .oHsync(oHsync), .oVsync(oVsync), .oDe(oDe),
    .oFrameStart(oFrameStart), .oFrameCount(oFrameCount)
  );

  always #5 iClk = ~iClk;

  int assert_cnt = 0;
  int fail_cnt = 0;

  // Reference model state
  int             k, m_mode, m_phase, m_x, m_y;
  logic [23:0]    m_color;
  logic [11:0]    e_data;
  logic           e_hs, e_vs, e_de, e_fs;
  logic [FCW-1:0] e_fcnt;

  function automatic logic [15+FCW:0] obs_v();
    return {oData, oHsync, oVsync, oDe, oFrameStart, oFrameCount};
  endfunction

  function automatic logic [15+FCW:0] exp_v();
    return {e_data, e_hs, e_vs, e_de, e_fs, e_fcnt};
  endfunction

  function automatic logic [23:0] model_rgb(int mode, int x, int y, logic [23:0] col);
    logic [23:0] c;
    int b;
    b = x / (24 / 8);
    if (b > 7) b = 7;
    case (mode)
      0:       c = BAR_TAB[b];
      1:       c = col;
      2:       c = ((((x >> 2) ^ (y >> 2)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: c = {3{8'(x % 256)}};
    endcase
`ifdef DVI_PATTERN_BORDER_EN
    if (x < 2 || x >= 22 || y < 2 || y >= 14) c = 24'hFFFFFF;
`endif
    return c;
  endfunction

  task automatic model_reset();
    k = 0; m_mode = 0; m_phase = 0; m_x = 0; m_y = 0; m_color = '0;
    e_data = '0; e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_fs = 1'b0; e_fcnt = '0;
  endtask

  // Advance one clock and update the model's expected outputs for that edge
  task automatic step();
    logic en_s, rst_s;
    logic [1:0] mode_s;
    logic [23:0] col_s, rgb;
    int s, h, v;
    en_s = iEnable; rst_s = iRst; mode_s = iMode; col_s = iColor;
    @(posedge iClk);
    #1;
    if (rst_s || !en_s) begin
      model_reset();
    end else begin
      s = k % FRAME_CLK;
      m_phase = s % 2;
      h = (s / 2) % HT;
      v = (s / 2) / HT;
      m_x = h - H_ACT_START;
      m_y = v;
      e_de = (h >= H_ACT_START) && (v < 16);
      e_hs = !(h >= 2 && h < 10);
      e_vs = !(v >= 18 && v < 22);
      e_fs = (s == 0);
      if (m_phase == 0) m_color = col_s;
      rgb = model_rgb(m_mode, m_x, m_y, m_color);
      if (!e_de) e_data = 12'h000;
      else if (m_phase == 0) e_data = {rgb[11:8], rgb[7:0]};
      else e_data = {rgb[23:16], rgb[15:12]};
      if (e_fs) begin
        m_mode = int'(mode_s);
        e_fcnt = e_fcnt + 1'b1;
      end
      k++;
    end
  endtask

  task automatic restart(input logic [1:0] mode);
    iEnable = 1'b0;
    step();
    iMode = mode;
    iEnable = 1'b1;
  endtask

  task automatic test_reset();
    iRst = 1'b1; iEnable = 1'b0; iMode = 2'd0; iColor = 24'h0;
    model_reset();
    #3;
    assert_cnt++;
    if (obs_v() !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, {FCW{1'b0}}}) begin
      fail_cnt++; $display("FAIL reset_state: got %h required %h", obs_v(), exp_v());
    end
    #20;
    iRst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL reset_idle: got %h required %h", obs_v(), exp_v());
      end
    end
  endtask

  task automatic test_timing();
    int hs_low, vs_low, de_hi, fs_cnt, de_lines, line_de;
    hs_low = 0; vs_low = 0; de_hi = 0; fs_cnt = 0; de_lines = 0; line_de = 0;
    iColor = $urandom;
    restart(2'd1);
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      if (i == 0) begin
        assert_cnt++;
        if (oFrameStart !== 1'b1) begin
          fail_cnt++; $display("FAIL first_frame_start: got %b required 1", oFrameStart);
        end
      end
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL timing_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      hs_low += (oHsync == 1'b0) ? 1 : 0;
      vs_low += (oVsync == 1'b0) ? 1 : 0;
      de_hi += (oDe == 1'b1) ? 1 : 0;
      fs_cnt += (oFrameStart == 1'b1) ? 1 : 0;
      line_de += (oDe == 1'b1) ? 1 : 0;
      if ((i % (2 * HT)) == 2 * HT - 1) begin
        if (line_de == 48) de_lines++;
        line_de = 0;
      end
    end
    step();
    assert_cnt++;
    if (oFrameStart !== 1'b1) begin
      fail_cnt++; $display("FAIL frame_period: frame start got %b required 1 after 2280 clocks", oFrameStart);
    end
    assert_cnt++;
    if (hs_low != 16 * VT) begin
      fail_cnt++; $display("FAIL hsync_low_clocks: got %0d required %0d", hs_low, 16 * VT);
    end
    assert_cnt++;
    if (vs_low != 4 * 2 * HT) begin
      fail_cnt++; $display("FAIL vsync_low_clocks: got %0d required %0d", vs_low, 4 * 2 * HT);
    end
    assert_cnt++;
    if (de_hi != 48 * 16 || de_lines != 16) begin
      fail_cnt++; $display("FAIL de_clocks: got %0d in %0d lines required 768 in 16", de_hi, de_lines);
    end
    assert_cnt++;
    if (fs_cnt != 1) begin
      fail_cnt++; $display("FAIL frame_start_count: got %0d required 1", fs_cnt);
    end
  endtask

  task automatic test_solid();
    iColor = 24'h123456;
    restart(2'd1);
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL solid_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if (oDe === 1'b1) begin
        assert_cnt++;
        if (oData !== ((m_phase == 0) ? 12'h456 : 12'h123)) begin
          fail_cnt++; $display("FAIL solid_halfword phase=%0d: got %h", m_phase, oData);
        end
      end
    end
  endtask

  task automatic test_bars();
    logic [11:0] want;
    iColor = $urandom;
    restart(2'd0);
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL bars_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if (e_de && m_y >= 2 && m_y < 14 && (m_x <= 2 || m_x == 15 || m_x >= 21) && m_x < 22 && m_x >= 2) begin
        if (m_x <= 2) want = 12'hFFF;
        else if (m_x == 15) want = (m_phase == 0) ? 12'h000 : 12'hFF0;
        else want = 12'h000;
        assert_cnt++;
        if (oData !== want) begin
          fail_cnt++; $display("FAIL bars_pixel x=%0d phase=%0d: got %h required %h", m_x, m_phase, oData, want);
        end
      end
    end
  endtask

  task automatic test_mode_switch();
    bit seen_fs;
    seen_fs = 0;
    iColor = $urandom;
    restart(2'd0);
    for (int i = 0; i < 1000; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL switch_pre k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
    end
    iMode = 2'd2;
    for (int i = 0; i < FRAME_CLK + 2 * HT && !(seen_fs && m_y == 1); i++) begin
      step();
      if (oFrameStart === 1'b1) seen_fs = 1;
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL switch_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
`ifndef DVI_PATTERN_BORDER_EN
      if (!seen_fs && e_de && m_x == 15 && m_phase == 1) begin
        assert_cnt++;
        if (oData !== 12'hFF0) begin
          fail_cnt++; $display("FAIL switch_bars_hold: got %h required ff0", oData);
        end
      end
      if (seen_fs && e_de && m_y == 0 && (m_x == 0 || m_x == 4)) begin
        assert_cnt++;
        if (oData !== ((m_x == 4) ? 12'hFFF : 12'h000)) begin
          fail_cnt++; $display("FAIL switch_checker x=%0d: got %h", m_x, oData);
        end
      end
`endif
    end
    assert_cnt++;
    if (!seen_fs) begin
      fail_cnt++; $display("FAIL switch_frame_start: got none required one within budget");
    end
  endtask

  task automatic test_border();
    iColor = 24'h000000;
    restart(2'd1);
    for (int i = 0; i < FRAME_CLK; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL border_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if (e_de && m_y == 5 && (m_x == 0 || m_x == 23)) begin
        assert_cnt++;
`ifdef DVI_PATTERN_BORDER_EN
        if (oData !== 12'hFFF) begin
          fail_cnt++; $display("FAIL border_pixel x=%0d: got %h required fff", m_x, oData);
        end
`else
        if (oData !== 12'h000) begin
          fail_cnt++; $display("FAIL border_pixel x=%0d: got %h required 000", m_x, oData);
        end
`endif
      end
    end
  endtask

  task automatic test_enable_toggle();
    iColor = $urandom;
    restart(2'd3);
    for (int i = 0; i < 1200; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL ramp_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
    end
    iEnable = 1'b0;
    step();
    assert_cnt++;
    if (obs_v() !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, {FCW{1'b0}}}) begin
      fail_cnt++; $display("FAIL disable_state: got %h required reset values", obs_v());
    end
    iEnable = 1'b1;
    step();
    assert_cnt++;
    if (oFrameStart !== 1'b1 || oFrameCount !== FCW'(1)) begin
      fail_cnt++; $display("FAIL reenable_frame_start: got fs=%b cnt=%0d required fs=1 cnt=1", oFrameStart, oFrameCount);
    end
  endtask

  task automatic test_frame_wrap();
    int n_fs;
    bit wrapped;
    n_fs = 0; wrapped = 0;
    iColor = $urandom;
    restart(2'($urandom_range(0, 3)));
    for (int i = 0; i < 8 * FRAME_CLK; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL wrap_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if (oFrameStart === 1'b1) begin
        n_fs++;
        assert_cnt++;
        if (oFrameCount !== FCW'(n_fs % 8)) begin
          fail_cnt++; $display("FAIL frame_count frame=%0d: got %0d required %0d", n_fs, oFrameCount, n_fs % 8);
        end
        if (n_fs == 8 && oFrameCount === '0) wrapped = 1;
      end
    end
    assert_cnt++;
    if (!wrapped || n_fs != 8) begin
      fail_cnt++; $display("FAIL frame_count_wrap: got %0d pulses wrap=%0d required 8 pulses wrap=1", n_fs, wrapped);
    end
  endtask

  task automatic test_random();
    iColor = $urandom;
    restart(2'($urandom_range(0, 3)));
    for (int i = 0; i < 2 * FRAME_CLK; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL random_cycle k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if ($urandom_range(0, 1) == 0) iColor = $urandom;
      if ($urandom_range(0, 499) == 0) iMode = 2'($urandom_range(0, 3));
      iEnable = ($urandom_range(0, 1999) != 0);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 0;
    iColor = 24'h000000;
    restart(2'd1);
    for (int i = 0; i < FRAME_CLK && !found; i++) begin
      step();
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL async_pre k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
      if (e_de && m_x == 10) found = 1;
    end
    assert_cnt++;
    if (!found) begin
      fail_cnt++; $display("FAIL async_reach_active: got none required active pixel");
    end
    #2;
    iRst = 1'b1;
    #1;
    assert_cnt++;
    if (obs_v() !== {12'h000, 1'b1, 1'b1, 1'b0, 1'b0, {FCW{1'b0}}}) begin
      fail_cnt++; $display("FAIL async_reset_state: got %h required reset values", obs_v());
    end
    model_reset();
    step();
    iRst = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (i == 0) begin
        assert_cnt++;
        if (oFrameStart !== 1'b1 || oFrameCount !== FCW'(1)) begin
          fail_cnt++; $display("FAIL post_reset_restart: got fs=%b cnt=%0d required fs=1 cnt=1", oFrameStart, oFrameCount);
        end
      end
      assert_cnt++;
      if (obs_v() !== exp_v()) begin
        fail_cnt++; $display("FAIL async_post k=%0d: got %h required %h", k, obs_v(), exp_v());
      end
    end
  endtask

  initial begin
    test_reset();
    test_timing();
    test_solid();
    test_bars();
    test_mode_switch();
    test_border();
    test_enable_toggle();
    test_frame_wrap();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
